// File: rtl/lot_pkg.sv
// Shared encodings for the lottery scoreboard: prize codes, point values,
// winner codes and the game FSM states.
package lot_pkg;

  localparam logic [1:0] PREMIO_NENHUM = 2'b00;
  localparam logic [1:0] PREMIO_PEQ    = 2'b01;
  localparam logic [1:0] PREMIO_MED    = 2'b10;
  localparam logic [1:0] PREMIO_GRANDE = 2'b11;

  localparam logic [4:0] PTS_NENHUM = 5'd0;
  localparam logic [4:0] PTS_PEQ    = 5'd2;
  localparam logic [4:0] PTS_MED    = 5'd5;
  localparam logic [4:0] PTS_GRANDE = 5'd10;
  localparam logic [4:0] SCORE_MAX  = 5'd31;

  localparam logic [1:0] VENC_NENHUM = 2'b00;
  localparam logic [1:0] VENC_P1     = 2'b01;
  localparam logic [1:0] VENC_P2     = 2'b10;
  localparam logic [1:0] VENC_EMPATE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_EVAL = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  function automatic logic [4:0] pts_of(input logic [1:0] code);
    logic [4:0] pts;
    case (code)
      PREMIO_PEQ:    pts = PTS_PEQ;
      PREMIO_MED:    pts = PTS_MED;
      PREMIO_GRANDE: pts = PTS_GRANDE;
      default:       pts = PTS_NENHUM;
    endcase
    return pts;
  endfunction

  function automatic logic [1:0] vencedor_de(input logic [4:0] a, input logic [4:0] b);
    logic [1:0] v;
    if (a > b)      v = VENC_P1;
    else if (b > a) v = VENC_P2;
    else            v = VENC_EMPATE;
    return v;
  endfunction

endpackage

// File: rtl/lot_placar_soma.sv
// Prize-to-points mapping plus a saturating 5-bit add; the sum is formed
// 6 bits wide so a carry out clamps to the maximum score instead of wrapping.
module lot_soma_sat
  import lot_pkg::*;
(
  input  logic [4:0] score,
  input  logic [1:0] premio,
  output logic [4:0] soma
);

  logic [5:0] sum_w;

  assign sum_w = {1'b0, score} + {1'b0, pts_of(premio)};
  assign soma  = (sum_w > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum_w[4:0];

endmodule

// File: rtl/lot_placar.sv
// Scoreboard / game controller downstream of the ticket checker: alternates
// turns, accumulates saturating scores, ends the game and reports the winner.
module lot_placar
  import lot_pkg::*;
#(
  parameter int ROUNDS = 5,
  parameter int TARGET = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       premio_valid,
  input  logic [1:0] premio,
  output logic       pronto,
  output logic       turno,
  output logic [3:0] rodada,
  output logic [4:0] p1,
  output logic [4:0] p2,
  output logic       fim_jogo,
  output logic [1:0] vencedor
);

  localparam logic [3:0] ROUNDS_L = 4'(ROUNDS);
  localparam logic [4:0] TARGET_L = 5'(TARGET);

  state_t     state, state_n;
  logic [4:0] p1_n, p2_n;
  logic [4:0] soma_in, soma;
  logic [3:0] rodada_n;
  logic       turno_n;
  logic       fim_n;
  logic [1:0] venc_n;

  // One adder shared by both players; turno picks whose score it extends.
  assign soma_in = turno ? p2 : p1;

  lot_soma_sat u_soma (
    .score  (soma_in),
    .premio (premio),
    .soma   (soma)
  );

  assign pronto = (state == ST_PLAY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      p1       <= '0;
      p2       <= '0;
      rodada   <= '0;
      turno    <= 1'b0;
      fim_jogo <= 1'b0;
      vencedor <= VENC_NENHUM;
    end else begin
      state    <= state_n;
      p1       <= p1_n;
      p2       <= p2_n;
      rodada   <= rodada_n;
      turno    <= turno_n;
      fim_jogo <= fim_n;
      vencedor <= venc_n;
    end
  end

  // End-of-game is decided on the scoring edge from the updated values so
  // that fim_jogo and vencedor come out of flops during the EVAL cycle.
  always_comb begin
    state_n  = state;
    p1_n     = p1;
    p2_n     = p2;
    rodada_n = rodada;
    turno_n  = turno;
    fim_n    = 1'b0;
    venc_n   = vencedor;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n  = ST_PLAY;
          p1_n     = '0;
          p2_n     = '0;
          rodada_n = '0;
          turno_n  = 1'b0;
          venc_n   = VENC_NENHUM;
        end
      end
      ST_PLAY: begin
        if (premio_valid) begin
          if (turno) p2_n = soma;
          else       p1_n = soma;
          rodada_n = rodada + {3'b000, turno};
          turno_n  = ~turno;
          state_n  = ST_EVAL;
          if ((p1_n >= TARGET_L) || (p2_n >= TARGET_L) || (rodada_n == ROUNDS_L)) begin
            fim_n  = 1'b1;
            venc_n = vencedor_de(p1_n, p2_n);
          end
        end
      end
      ST_EVAL: begin
        state_n = fim_jogo ? ST_DONE : ST_PLAY;
      end
      ST_DONE: begin
        if (start) begin
          state_n  = ST_PLAY;
          p1_n     = '0;
          p2_n     = '0;
          rodada_n = '0;
          turno_n  = 1'b0;
          venc_n   = VENC_NENHUM;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lot_placar.sv
// Self-checking bench: three parameterizations share one stimulus stream and
// are each compared every cycle against a behavioural game model.
module tb_lot_placar;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       reset, start, premio_valid;
  logic [1:0] premio;

  logic       pronto_o [N];
  logic       turno_o  [N];
  logic [3:0] rodada_o [N];
  logic [4:0] p1_o     [N];
  logic [4:0] p2_o     [N];
  logic       fim_o    [N];
  logic [1:0] venc_o   [N];

  lot_placar #(.ROUNDS(5), .TARGET(20)) u0 (
    .clk(clk), .reset(reset), .start(start), .premio_valid(premio_valid), .premio(premio),
    .pronto(pronto_o[0]), .turno(turno_o[0]), .rodada(rodada_o[0]), .p1(p1_o[0]), .p2(p2_o[0]),
    .fim_jogo(fim_o[0]), .vencedor(venc_o[0]));

  lot_placar #(.ROUNDS(3), .TARGET(20)) u1 (
    .clk(clk), .reset(reset), .start(start), .premio_valid(premio_valid), .premio(premio),
    .pronto(pronto_o[1]), .turno(turno_o[1]), .rodada(rodada_o[1]), .p1(p1_o[1]), .p2(p2_o[1]),
    .fim_jogo(fim_o[1]), .vencedor(venc_o[1]));

  lot_placar #(.ROUNDS(5), .TARGET(31)) u2 (
    .clk(clk), .reset(reset), .start(start), .premio_valid(premio_valid), .premio(premio),
    .pronto(pronto_o[2]), .turno(turno_o[2]), .rodada(rodada_o[2]), .p1(p1_o[2]), .p2(p2_o[2]),
    .fim_jogo(fim_o[2]), .vencedor(venc_o[2]));

  always #5 clk = ~clk;

  // Behavioural model: game phase, scores, round count, whose turn
  localparam int M_IDLE = 0, M_PLAY = 1, M_EVAL = 2, M_DONE = 3;
  int rounds_of [N] = '{5, 3, 5};
  int target_of [N] = '{20, 20, 31};
  int m_phase [N], m_p1 [N], m_p2 [N], m_rod [N], m_turn [N], m_fim [N], m_venc [N];

  int checks   = 0;
  int failures = 0;

  function automatic int pts(input int code);
    int tbl [4] = '{0, 2, 5, 10};
    return tbl[code];
  endfunction

  function automatic int sat(input int v);
    return (v > 31) ? 31 : v;
  endfunction

  task automatic m_clear(input int k);
    m_phase[k] = M_IDLE; m_p1[k] = 0; m_p2[k] = 0; m_rod[k] = 0;
    m_turn[k] = 0; m_fim[k] = 0; m_venc[k] = 0;
  endtask

  task automatic m_new_game(input int k);
    m_p1[k] = 0; m_p2[k] = 0; m_rod[k] = 0; m_turn[k] = 0; m_venc[k] = 0;
    m_phase[k] = M_PLAY;
  endtask

  task automatic m_step(input int k);
    int ended;
    ended = m_fim[k];
    m_fim[k] = 0;
    if (reset) begin
      m_clear(k);
    end else begin
      case (m_phase[k])
        M_IDLE: if (start) m_new_game(k);
        M_PLAY: if (premio_valid) begin
          if (m_turn[k] == 0) m_p1[k] = sat(m_p1[k] + pts(int'(premio)));
          else begin
            m_p2[k] = sat(m_p2[k] + pts(int'(premio)));
            m_rod[k]++;
          end
          m_turn[k] = 1 - m_turn[k];
          m_phase[k] = M_EVAL;
          if (m_p1[k] >= target_of[k] || m_p2[k] >= target_of[k] || m_rod[k] == rounds_of[k]) begin
            m_fim[k] = 1;
            m_venc[k] = (m_p1[k] > m_p2[k]) ? 1 : (m_p2[k] > m_p1[k]) ? 2 : 3;
          end
        end
        M_EVAL: m_phase[k] = ended ? M_DONE : M_PLAY;
        default: if (start) m_new_game(k);
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      check($sformatf("u%0d_pronto", k), 32'(pronto_o[k]), 32'(m_phase[k] == M_PLAY));
      check($sformatf("u%0d_turno", k),  32'(turno_o[k]),  32'(m_turn[k]));
      check($sformatf("u%0d_rodada", k), 32'(rodada_o[k]), 32'(m_rod[k]));
      check($sformatf("u%0d_p1", k),     32'(p1_o[k]),     32'(m_p1[k]));
      check($sformatf("u%0d_p2", k),     32'(p2_o[k]),     32'(m_p2[k]));
      check($sformatf("u%0d_fim", k),    32'(fim_o[k]),    32'(m_fim[k]));
      check($sformatf("u%0d_venc", k),   32'(venc_o[k]),   32'(m_venc[k]));
    end
  endtask

  task automatic tick(input logic s, input logic v, input logic [1:0] p);
    start = s; premio_valid = v; premio = p;
    @(posedge clk);
    for (int k = 0; k < N; k++) m_step(k);
    #1;
    check_all();
  endtask

  // Reset asserted between edges must take effect without a clock.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    for (int k = 0; k < N; k++) m_clear(k);
    check_all();
    tick(1'b0, 1'b0, 2'b00);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; premio_valid = 1'b0; premio = 2'b00;
    for (int k = 0; k < N; k++) m_clear(k);
    #2;
    check_all();
    tick(1'b0, 1'b0, 2'b00);
    reset = 1'b0;
    tick(1'b0, 1'b0, 2'b00);

    // Mid-game reset with p1 = 7
    tick(1'b1, 1'b0, 2'b00);
    tick(1'b0, 1'b1, 2'b10); tick(1'b0, 1'b0, 2'b00);
    tick(1'b0, 1'b1, 2'b00); tick(1'b0, 1'b0, 2'b00);
    tick(1'b0, 1'b1, 2'b01); tick(1'b0, 1'b0, 2'b00);
    check("pre_reset_p1", 32'(p1_o[0]), 32'd7);
    do_reset();
    check("post_reset_p1", 32'(p1_o[0]), 32'd0);

    // Threshold win on u0: 10, 2, 20
    tick(1'b1, 1'b0, 2'b00);
    tick(1'b0, 1'b1, 2'b11); tick(1'b0, 1'b0, 2'b00);
    tick(1'b0, 1'b1, 2'b01); tick(1'b0, 1'b0, 2'b00);
    tick(1'b0, 1'b1, 2'b11);
    check("thr_fim", 32'(fim_o[0]), 32'd1);
    check("thr_venc", 32'(venc_o[0]), 32'd1);
    check("thr_rodada", 32'(rodada_o[0]), 32'd1);
    tick(1'b0, 1'b0, 2'b00);
    check("thr_fim_off", 32'(fim_o[0]), 32'd0);
    check("thr_pronto", 32'(pronto_o[0]), 32'd0);

    // Round-limit tie on u1 (ROUNDS = 3)
    do_reset();
    tick(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b1, 2'b01);
      if (i == 5) begin
        check("tie_fim", 32'(fim_o[1]), 32'd1);
        check("tie_venc", 32'(venc_o[1]), 32'd3);
        check("tie_p2", 32'(p2_o[1]), 32'd6);
      end
      tick(1'b0, 1'b0, 2'b00);
    end

    // Saturation on u2 (TARGET = 31): 10, 20, 30, 31
    do_reset();
    tick(1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 2'b11);
      tick(1'b0, 1'b0, 2'b00);
      if (i < 3) begin
        tick(1'b0, 1'b1, 2'b00);
        tick(1'b0, 1'b0, 2'b00);
      end
    end
    check("sat_p1", 32'(p1_o[2]), 32'd31);
    check("sat_venc", 32'(venc_o[2]), 32'd1);

    // Restart from DONE, then a start pulse mid-game is ignored
    tick(1'b1, 1'b0, 2'b00);
    check("rst_pronto", 32'(pronto_o[2]), 32'd1);
    check("rst_venc", 32'(venc_o[2]), 32'd0);
    tick(1'b0, 1'b1, 2'b11); tick(1'b0, 1'b0, 2'b00);
    tick(1'b1, 1'b0, 2'b00);
    check("start_in_play_p1", 32'(p1_o[2]), 32'd10);

    // Back-to-back valids: the second lands in EVAL and is dropped
    do_reset();
    tick(1'b1, 1'b0, 2'b00);
    tick(1'b0, 1'b1, 2'b11);
    tick(1'b0, 1'b1, 2'b11);
    tick(1'b0, 1'b0, 2'b00);
    check("drop_p1", 32'(p1_o[0]), 32'd10);
    check("drop_turno", 32'(turno_o[0]), 32'd1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else tick(1'($urandom_range(0, 99) < 6), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
